instr_fetch: RTL and testbench

//   Fetch stage driving the synchronous instruction ROM (registered read: data for addr

---
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues ROM reads and hands (pc, instr) pairs to decode.
// A one-entry skid buffer absorbs the registered ROM latency under back-pressure.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    output logic [2:0]  rom_size,
    input  logic [31:0] rom_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic [31:0] fetch_pc;
    logic        pend_v;
    logic [31:0] pend_pc;
    logic        skid_v;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        out_v;
    logic [31:0] out_pc_q;
    logic [31:0] out_instr_q;

    logic issue;
    logic advance;

    assign rom_addr  = fetch_pc;
    assign rom_size  = 3'b010;
    assign out_valid = out_v;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

    // Stop issuing whenever a returning word might have nowhere to land.
    assign issue   = !skid_v && !(pend_v && out_v && !out_ready) && !redirect_valid;
    assign advance = !out_v || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            pend_v      <= 1'b0;
            pend_pc     <= 32'h0;
            skid_v      <= 1'b0;
            skid_pc     <= 32'h0;
            skid_instr  <= 32'h0;
            out_v       <= 1'b0;
            out_pc_q    <= 32'h0;
            out_instr_q <= 32'h0;
        end else if (redirect_valid) begin
            pend_v   <= 1'b0;
            skid_v   <= 1'b0;
            out_v    <= 1'b0;
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else begin
            pend_v <= issue;
            if (issue) begin
                pend_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (advance) begin
                if (skid_v) begin
                    out_v       <= 1'b1;
                    out_pc_q    <= skid_pc;
                    out_instr_q <= skid_instr;
                    skid_v      <= pend_v;
                    if (pend_v) begin
                        skid_pc    <= pend_pc;
                        skid_instr <= rom_rd;
                    end
                end else if (pend_v) begin
                    out_v       <= 1'b1;
                    out_pc_q    <= pend_pc;
                    out_instr_q <= rom_rd;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (pend_v) begin
                skid_v     <= 1'b1;
                skid_pc    <= pend_pc;
                skid_instr <= rom_rd;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed latency/redirect/reset cases plus a random phase,
// with a scoreboard of expected PCs per fetch epoch popped by an output monitor.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr;
    logic [2:0]  rom_size;
    logic [31:0] rom_rd = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] next_pc;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .rst(rst),
        .rom_addr(rom_addr),
        .rom_size(rom_size),
        .rom_rd(rom_rd),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    // Synchronous ROM with one-cycle registered read
    always @(posedge clk) rom_rd <= rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: each epoch delivers consecutive words from its start PC
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            next_pc = RST_PC;
        end else if (redirect_valid) begin
            exp_q.delete();
            next_pc = {redirect_pc[31:2], 2'b00};
        end
        while (exp_q.size() < 32) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_instr;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'h0, out_valid}, 32'h1);
                chk("stall_pc", out_pc, prev_pc);
                chk("stall_instr", out_instr, prev_instr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", out_pc, 32'hxxxx_xxxx);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("sb_pc", out_pc, e);
                    chk("sb_instr", out_instr, rom_word(e));
                end
            end
            prev_stall = out_valid && !out_ready && !redirect_valid;
            prev_pc    = out_pc;
            prev_instr = out_instr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        out_ready      = rdy;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk("redir_t1_valid", {31'h0, out_valid}, 32'h0);
        chk("redir_t1_addr", rom_addr, {pc[31:2], 2'b00});
        step();
        chk("redir_t2_valid", {31'h0, out_valid}, 32'h0);
        step();
        chk("redir_t3_valid", {31'h0, out_valid}, 32'h1);
        chk("redir_t3_pc", out_pc, {pc[31:2], 2'b00});
    endtask

    initial begin
        logic [31:0] a1;
        // Reset state
        #2;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_addr", rom_addr, RST_PC);
        chk("rst_size", {29'h0, rom_size}, 32'h2);
        chk("rst_pc", out_pc, 32'h0);
        step();
        rst = 1'b0;
        // Test 1: release latency and gapless stream
        step();
        chk("t1_c1_valid", {31'h0, out_valid}, 32'h0);
        step();
        chk("t1_c2_valid", {31'h0, out_valid}, 32'h1);
        chk("t1_c2_pc", out_pc, RST_PC);
        chk("t1_c2_instr", out_instr, 32'hA000_0000);
        for (int k = 1; k < 8; k++) begin
            step();
            chk("t1_stream_valid", {31'h0, out_valid}, 32'h1);
            chk("t1_stream_pc", out_pc, RST_PC + 32'(4 * k));
        end
        // Test 2: three-cycle stall, no issue while skid full
        out_ready = 1'b0;
        step();
        step();
        a1 = rom_addr;
        step();
        chk("t2_addr_held", rom_addr, a1);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        // Test 3: redirect while skid is full
        out_ready = 1'b0;
        step();
        step();
        redirect_to(32'h0000_0103, 1'b0);
        for (int k = 0; k < 4; k++) step();
        // Test 4: redirect with stall and pend arrival in same cycle
        redirect_to(32'h0000_0200, 1'b0);
        for (int k = 0; k < 4; k++) step();
        // Test 5: PC wrap
        redirect_to(32'hFFFF_FFF8, 1'b1);
        step();
        chk("t5_pc_fffc", out_pc, 32'hFFFF_FFFC);
        step();
        chk("t5_pc_wrap", out_pc, 32'h0000_0000);
        chk("t5_valid", {31'h0, out_valid}, 32'h1);
        step();
        // Test 6: async reset mid-stream
        chk("t6_pre_valid", {31'h0, out_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'h0, out_valid}, 32'h0);
        chk("t6_async_addr", rom_addr, RST_PC);
        step();
        rst = 1'b0;
        step();
        chk("t6_c1_valid", {31'h0, out_valid}, 32'h0);
        step();
        chk("t6_c2_valid", {31'h0, out_valid}, 32'h1);
        chk("t6_c2_pc", out_pc, RST_PC);
        // Random phase
        for (int k = 0; k < 600; k++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            else
                redirect_pc = $urandom;
            step();
        end
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
